// File: rtl/vga_capture_monitor.sv
// VGA capture monitor: measures the incoming raster, locks onto the expected
// geometry, counts frames while locked, and emits a decimated (1-in-8 in both
// axes) RGB332 write stream for an 80x60 capture buffer.
module vga_capture_monitor #(
  parameter int   H_ACTIVE = 640,
  parameter int   V_ACTIVE = 480,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vgaClk,
  input  logic        hSync,
  input  logic        vSync,
  input  logic        bright,
  input  logic [23:0] rgb,
  output logic        locked,
  output logic        syncErr,
  output logic [9:0]  hPixels,
  output logic [9:0]  vLines,
  output logic [15:0] frameCount,
  output logic        wrEn,
  output logic [12:0] wrAddr,
  output logic [7:0]  wrData
);

  localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
  localparam logic [9:0] CNT_MAX = 10'h3FF;

  typedef enum logic [1:0] {SEEK, MEASURE, LOCKED} state_t;

  state_t      state_q, state_d;
  logic        hs_prev_q, hs_prev_d;
  logic        vs_prev_q, vs_prev_d;
  logic [9:0]  px_cnt_q, px_cnt_d;
  logic [9:0]  ln_cnt_q, ln_cnt_d;
  logic [9:0]  h_pixels_q, h_pixels_d;
  logic [9:0]  v_lines_q, v_lines_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        meas_bad_q, meas_bad_d;
  logic        sync_err_q, sync_err_d;
  logic        wr_en_q, wr_en_d;
  logic [12:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;

  logic        hs_edge, vs_edge;
  logic        line_close, line_bad, frame_bad;
  logic [9:0]  ln_after_h;
  logic        cap_hit;
  logic [12:0] cap_addr;

  // Only the top bits of each colour channel reach the capture buffer.
  logic unused_rgb_bits;
  assign unused_rgb_bits = ^{rgb[20:16], rgb[12:8], rgb[5:0]};

  // Edge detection and line/frame close qualifiers for the current sample.
  always_comb begin
    hs_edge    = vgaClk && (hSync == SYNC_POL) && (hs_prev_q != SYNC_POL);
    vs_edge    = vgaClk && (vSync == SYNC_POL) && (vs_prev_q != SYNC_POL);
    line_close = hs_edge && (px_cnt_q != 10'd0);
    line_bad   = line_close && (px_cnt_q != H_ACT);
    // hSync is handled before vSync, so a line closing on the vSync sample
    // is already included in the frame height.
    ln_after_h = (line_close && (ln_cnt_q != CNT_MAX)) ? ln_cnt_q + 10'd1 : ln_cnt_q;
    frame_bad  = (ln_after_h != V_ACT);
    // Address = (ln/8)*80 + px/8, with *80 formed as *64 + *16.
    cap_addr   = {ln_cnt_q[9:3], 6'b0} + {2'b0, ln_cnt_q[9:3], 4'b0} + {6'b0, px_cnt_q[9:3]};
    // Bounding to 640x480 keeps every address inside 0..4799.
    cap_hit    = vgaClk && (state_q == LOCKED) && bright &&
                 (px_cnt_q[2:0] == 3'd0) && (ln_cnt_q[2:0] == 3'd0) &&
                 (px_cnt_q < 10'd640) && (ln_cnt_q < 10'd480);
  end

  // Sync history, saturating pixel/line counters, measurements and capture port.
  always_comb begin
    hs_prev_d  = hs_prev_q;
    vs_prev_d  = vs_prev_q;
    px_cnt_d   = px_cnt_q;
    ln_cnt_d   = ln_cnt_q;
    h_pixels_d = h_pixels_q;
    v_lines_d  = v_lines_q;
    wr_en_d    = cap_hit;
    wr_addr_d  = cap_hit ? cap_addr : wr_addr_q;
    wr_data_d  = cap_hit ? {rgb[23:21], rgb[15:13], rgb[7:6]} : wr_data_q;
    if (vgaClk) begin
      hs_prev_d = hSync;
      vs_prev_d = vSync;
      if (hs_edge) begin
        if (px_cnt_q != 10'd0) h_pixels_d = px_cnt_q;
        px_cnt_d = 10'd0;
      end else if (bright && (px_cnt_q != CNT_MAX)) begin
        px_cnt_d = px_cnt_q + 10'd1;
      end
      ln_cnt_d = ln_after_h;
      if (vs_edge) begin
        v_lines_d = ln_after_h;
        ln_cnt_d  = 10'd0;
      end
    end
  end

  // Lock FSM next state, error pulse and frame counter.
  always_comb begin
    state_d     = state_q;
    meas_bad_d  = meas_bad_q;
    sync_err_d  = 1'b0;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      SEEK: begin
        if (vs_edge) begin
          state_d    = MEASURE;
          meas_bad_d = 1'b0;
        end
      end
      MEASURE: begin
        if (line_bad) meas_bad_d = 1'b1;
        if (vs_edge) begin
          if (!frame_bad && !meas_bad_q && !line_bad) state_d = LOCKED;
          meas_bad_d = 1'b0;
        end
      end
      LOCKED: begin
        if (line_bad || (vs_edge && frame_bad)) begin
          sync_err_d = 1'b1;
          state_d    = SEEK;
        end else if (vs_edge) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
        end
      end
      default: state_d = SEEK;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= SEEK;
    else      state_q <= state_d;
  end

  // Datapath registers; reset returns history to the idle sync level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hs_prev_q   <= ~SYNC_POL;
      vs_prev_q   <= ~SYNC_POL;
      px_cnt_q    <= '0;
      ln_cnt_q    <= '0;
      h_pixels_q  <= '0;
      v_lines_q   <= '0;
      frame_cnt_q <= '0;
      meas_bad_q  <= 1'b0;
      sync_err_q  <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      hs_prev_q   <= hs_prev_d;
      vs_prev_q   <= vs_prev_d;
      px_cnt_q    <= px_cnt_d;
      ln_cnt_q    <= ln_cnt_d;
      h_pixels_q  <= h_pixels_d;
      v_lines_q   <= v_lines_d;
      frame_cnt_q <= frame_cnt_d;
      meas_bad_q  <= meas_bad_d;
      sync_err_q  <= sync_err_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign locked     = (state_q == LOCKED);
  assign syncErr    = sync_err_q;
  assign hPixels    = h_pixels_q;
  assign vLines     = v_lines_q;
  assign frameCount = frame_cnt_q;
  assign wrEn       = wr_en_q;
  assign wrAddr     = wr_addr_q;
  assign wrData     = wr_data_q;

endmodule
